// File: rtl/frame_pkg.sv
// Shared types and helpers for the frame marker generator: FSM states,
// marker polarity variants, default sync patterns and the marker-word builder.
// Optional frame-number field is controlled by the FRAME_COUNT_EN macro.
package frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MARKER = 2'd1,
`ifdef FRAME_COUNT_EN
    ST_COUNT  = 2'd2,
`endif
    ST_DATA   = 2'd3
  } frame_state_t;

  // Marker polarity variants, rotated once per frame
  localparam logic [1:0] VAR_MB    = 2'd0;  // {M, B}
  localparam logic [1:0] VAR_NM_B  = 2'd1;  // {~M, B}
  localparam logic [1:0] VAR_M_NB  = 2'd2;  // {M, ~B}
  localparam logic [1:0] VAR_NM_NB = 2'd3;  // {~M, ~B}

  localparam logic [30:0] M_PATTERN_DEF = 31'b1111100110100100001010111011000;
  localparam logic [12:0] B_PATTERN_DEF = 13'b1111100110101;

  // Builds {Mv, Bv} right-aligned in a 128-bit word; callers truncate to M+B bits
  function automatic logic [127:0] marker_word(input logic [1:0]  v,
                                               input logic [63:0] m,
                                               input logic [63:0] b,
                                               input int          m_w,
                                               input int          b_w);
    logic [63:0] m_mask;
    logic [63:0] b_mask;
    logic [63:0] mv;
    logic [63:0] bv;
    logic        inv_m;
    logic        inv_b;
    m_mask = (m_w >= 64) ? '1 : ((64'd1 << m_w) - 64'd1);
    b_mask = (b_w >= 64) ? '1 : ((64'd1 << b_w) - 64'd1);
    inv_m  = (v == VAR_NM_B) || (v == VAR_NM_NB);
    inv_b  = (v == VAR_M_NB) || (v == VAR_NM_NB);
    mv     = (inv_m ? ~m : m) & m_mask;
    bv     = (inv_b ? ~b : b) & b_mask;
    marker_word = ({64'd0, mv} << b_w) | {64'd0, bv};
  endfunction

endpackage

// File: rtl/bit_slot_timer.sv
// Bit-slot sequencer: counts cycles 0..BIT_PERIOD-1 of each serial bit slot.
// Latency: slot_load is combinational in cycle 0, slot_strobe is cycle 1.
// Backpressure: a slot only leaves cycle 0 when start is high; otherwise it parks there.
module bit_slot_timer #(
  parameter int BIT_PERIOD = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic slot_load,
  output logic slot_strobe
);

  localparam int CW = $clog2(BIT_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(BIT_PERIOD - 1);

  logic [CW-1:0] cyc_cnt;

  assign slot_load   = (cyc_cnt == '0) && start;
  assign slot_strobe = (cyc_cnt == CW'(1));

  // Advance through the slot; hold at cycle 0 until a slot is allowed to start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_cnt <= '0;
    end else if (cyc_cnt == '0) begin
      if (start) cyc_cnt <= CW'(1);
    end else if (cyc_cnt == LAST) begin
      cyc_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/frame_marker_gen.sv
// Serial frame generator: rotating-polarity {M,B} marker, optional frame number
// (FRAME_COUNT_EN), then DATA_BITS payload bits; first oframe 2 clocks after ien.
// Backpressure: empty FIFO stalls a payload slot (or inserts FILL_BIT when FILL_ON_EMPTY=1).
module frame_marker_gen
  import frame_pkg::*;
#(
  parameter int                   M_WIDTH       = 31,
  parameter int                   B_WIDTH       = 13,
  parameter logic [M_WIDTH-1:0]   M_PATTERN     = M_PATTERN_DEF,
  parameter logic [B_WIDTH-1:0]   B_PATTERN     = B_PATTERN_DEF,
  parameter int                   DATA_BITS     = 2816,
  parameter int                   BIT_PERIOD    = 3,
  parameter int                   FILL_ON_EMPTY = 0,
`ifdef FRAME_COUNT_EN
  parameter int                   CNT_WIDTH     = 8,
`endif
  parameter logic                 FILL_BIT      = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic ien,
  input  logic iemp,
  input  logic idat,
  output logic orack,
  output logic odat,
  output logic oval,
  output logic oframe,
  output logic ounder
);

  localparam int MK_LEN = M_WIDTH + B_WIDTH;
  localparam logic [11:0] MK_LAST = 12'(MK_LEN - 1);
  localparam logic [11:0] D_LAST  = 12'(DATA_BITS - 1);
`ifdef FRAME_COUNT_EN
  localparam logic [11:0] C_LAST  = 12'(CNT_WIDTH - 1);
`endif

  frame_state_t      state;
  logic [11:0]       bit_cnt;
  logic [1:0]        var_idx;
  logic [MK_LEN-1:0] mk_word;
  logic [MK_LEN-1:0] mk_sh;
  logic              pend_rack;
  logic              pend_under;
  logic              pend_frame;
  logic              slot_start;
  logic              slot_load;
  logic              slot_strobe;
`ifdef FRAME_COUNT_EN
  logic [CNT_WIDTH-1:0] frame_no;
  logic [CNT_WIDTH-1:0] cnt_sh;
`endif

  assign mk_word = MK_LEN'(marker_word(var_idx, 64'(M_PATTERN), 64'(B_PATTERN), M_WIDTH, B_WIDTH));

  bit_slot_timer #(.BIT_PERIOD(BIT_PERIOD)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .start      (slot_start),
    .slot_load  (slot_load),
    .slot_strobe(slot_strobe)
  );

  // A slot may begin when the current state has a bit ready to send
  always_comb begin
    slot_start = 1'b0;
    case (state)
      ST_IDLE:   slot_start = ien;
      ST_MARKER: slot_start = 1'b1;
`ifdef FRAME_COUNT_EN
      ST_COUNT:  slot_start = 1'b1;
`endif
      ST_DATA:   slot_start = !iemp || (FILL_ON_EMPTY != 0);
      default:   slot_start = 1'b0;
    endcase
  end

  // Frame FSM: loads odat in slot cycle 0, fires the strobes from slot cycle 1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      var_idx    <= VAR_MB;
      mk_sh      <= '0;
      pend_rack  <= 1'b0;
      pend_under <= 1'b0;
      pend_frame <= 1'b0;
      odat       <= 1'b0;
      oval       <= 1'b0;
      orack      <= 1'b0;
      oframe     <= 1'b0;
      ounder     <= 1'b0;
`ifdef FRAME_COUNT_EN
      frame_no   <= '0;
      cnt_sh     <= '0;
`endif
    end else begin
      oval   <= slot_strobe;
      orack  <= slot_strobe & pend_rack;
      ounder <= slot_strobe & pend_under;
      oframe <= slot_strobe & pend_frame;
      if (slot_load) begin
        pend_rack  <= 1'b0;
        pend_under <= 1'b0;
        pend_frame <= 1'b0;
        case (state)
          ST_IDLE: begin
            // Start straight away with marker bit 0 to keep the start-up latency short
            odat       <= mk_word[MK_LEN-1];
            mk_sh      <= mk_word << 1;
            bit_cnt    <= 12'd1;
            pend_frame <= 1'b1;
            state      <= ST_MARKER;
          end
          ST_MARKER: begin
            odat       <= mk_sh[MK_LEN-1];
            mk_sh      <= mk_sh << 1;
            pend_frame <= (bit_cnt == 12'd0);
            if (bit_cnt == MK_LAST) begin
              bit_cnt <= '0;
              var_idx <= var_idx + 2'd1;
`ifdef FRAME_COUNT_EN
              cnt_sh  <= frame_no;
              state   <= ST_COUNT;
`else
              state   <= ST_DATA;
`endif
            end else begin
              bit_cnt <= bit_cnt + 12'd1;
            end
          end
`ifdef FRAME_COUNT_EN
          ST_COUNT: begin
            odat   <= cnt_sh[CNT_WIDTH-1];
            cnt_sh <= cnt_sh << 1;
            if (bit_cnt == C_LAST) begin
              bit_cnt <= '0;
              state   <= ST_DATA;
            end else begin
              bit_cnt <= bit_cnt + 12'd1;
            end
          end
`endif
          ST_DATA: begin
            // Only reachable with iemp=1 in fill mode; then the FIFO is left untouched
            odat       <= iemp ? FILL_BIT : idat;
            pend_rack  <= !iemp;
            pend_under <= iemp;
            if (bit_cnt == D_LAST) begin
              bit_cnt <= '0;
`ifdef FRAME_COUNT_EN
              frame_no <= frame_no + 1'b1;
`endif
              if (ien) begin
                mk_sh <= mk_word;
                state <= ST_MARKER;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + 12'd1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
